pipe_skid_reg: RTL

- Valid/ready pipeline register with a two-entry skid buffer, placed between two pipeline stages where the downstream stage can stall. First instance: execute to memory, carrying pipes::execute_data_t.
- Data flows forward and backpressure flows backward, with in_ready driven straight from a flop so there is no combinational ready path across stages.
- Supports a synchronous flush for branch redirect and exceptions.

---
 rtl/pipes_pkg.sv | 34 +++
 rtl/pipe_skid_reg.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipes_pkg.sv
// Shared pipeline types: stage payload structs and the skid-buffer debug state.
package pipes;

  // Payload handed from the execute stage to the memory stage.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
  } execute_data_t;

  // Occupancy of a skid register; derived from the two valid flops.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Map the valid flops onto the debug enum (skid without main is illegal).
  function automatic skid_state_e skid_state_of(input logic main_valid,
                                                input logic skid_valid);
    skid_state_e s;
    if (skid_valid)      s = FULL;
    else if (main_valid) s = ONE;
    else                 s = EMPTY;
    return s;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a two-entry skid buffer.
// Data moves forward through the main entry; the skid entry absorbs one beat
// when downstream stalls so that in_ready can come straight from a flop.
// Optional stall counter enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_reg
  import pipes::*;
#(
  parameter int           W          = $bits(execute_data_t),
  parameter logic [W-1:0] RESET_DATA = '0
) (
  input  logic         clk,
  input  logic         reset,      // asynchronous, active low
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]  stall_cycles
`endif
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;

  logic         w_main_valid_next;
  logic         w_skid_valid_next;
  logic         w_load_main_in;
  logic         w_load_main_skid;
  logic         w_load_skid_in;
  logic         w_accept;
  logic         w_pop;
  skid_state_e  w_state;

  // in_ready depends only on the skid flop: no combinational path from out_ready.
  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;

  assign w_accept = in_valid & ~r_skid_valid;
  assign w_pop    = r_main_valid & out_ready;
  assign w_state  = skid_state_of(r_main_valid, r_skid_valid);

  // Next occupancy and data-register load enables; flush wins over everything.
  always_comb begin
    w_main_valid_next = r_main_valid;
    w_skid_valid_next = r_skid_valid;
    w_load_main_in    = 1'b0;
    w_load_main_skid  = 1'b0;
    w_load_skid_in    = 1'b0;
    case (w_state)
      EMPTY: begin
        if (w_accept) begin
          w_main_valid_next = 1'b1;
          w_load_main_in    = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_skid_valid_next = 1'b1;
          w_load_skid_in    = 1'b1;
        end else if (w_pop) begin
          w_main_valid_next = 1'b0;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move state.
        if (w_pop) begin
          w_skid_valid_next = 1'b0;
          w_load_main_skid  = 1'b1;
        end
      end
      default: begin
        w_main_valid_next = r_main_valid;
        w_skid_valid_next = r_skid_valid;
      end
    endcase
    if (flush) begin
      // Discard everything held; data registers keep their old contents.
      w_main_valid_next = 1'b0;
      w_skid_valid_next = 1'b0;
      w_load_main_in    = 1'b0;
      w_load_main_skid  = 1'b0;
      w_load_skid_in    = 1'b0;
    end
  end

  // Valid flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_next;
      r_skid_valid <= w_skid_valid_next;
    end
  end

  // Main data register: refilled from the input or promoted from the skid entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_data <= RESET_DATA;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
    end else if (w_load_main_in) begin
      r_main_data <= in_data;
    end
  end

  // Skid data register: captures the beat accepted while the head is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skid_data <= RESET_DATA;
    end else if (w_load_skid_in) begin
      r_skid_data <= in_data;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] r_stall_cycles;

  // Count edges where the head is valid but downstream is not taking it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
    end else if (r_main_valid && !out_ready) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  // A skid entry can never exist without a head entry.
  a_skid_implies_main: assert property (
    @(posedge clk) disable iff (!reset) (r_skid_valid |-> r_main_valid)
  );

endmodule
